// File: rtl/data_sram_resp.sv
// Data SRAM port responder: byte-writable RAM plus an MMIO window with a timer,
// an LED register, a synchronised switch input and an unmapped-access counter.
module data_sram_resp #(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [15:0] MMIO_HI = 16'hBFAF,
  parameter int unsigned NUM_LED = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_sram_en,
  input  logic [3:0]         data_sram_wen,
  input  logic [31:0]        data_sram_addr,
  input  logic [31:0]        data_sram_wdata,
  output logic [31:0]        data_sram_rdata,
  output logic [NUM_LED-1:0] led,
  input  logic [7:0]         switch,
  output logic [7:0]         err_cnt
);

  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_SWITCH = 16'hF004;

  logic [31:0]        mem [2**ADDR_W];
  logic [31:0]        timer;
  logic [7:0]         sw_meta;
  logic [7:0]         sw_sync;

  logic               is_mmio;
  logic               is_wr;
  logic               hit_timer;
  logic               hit_led;
  logic               hit_switch;
  logic               hit_none;
  logic [ADDR_W-1:0]  word_idx;
  logic [31:0]        mmio_rdata;
  logic               unused_addr;

  assign unused_addr = ^data_sram_addr[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    is_mmio    = (data_sram_addr[31:16] == MMIO_HI);
    is_wr      = |data_sram_wen;
    hit_timer  = is_mmio && (data_sram_addr[15:2] == OFF_TIMER[15:2]);
    hit_led    = is_mmio && (data_sram_addr[15:2] == OFF_LED[15:2]);
    hit_switch = is_mmio && (data_sram_addr[15:2] == OFF_SWITCH[15:2]);
    hit_none   = is_mmio && !(hit_timer || hit_led || hit_switch);
    word_idx   = data_sram_addr[ADDR_W+1:2];
    mmio_rdata = '0;
    if (hit_timer)       mmio_rdata = timer;
    else if (hit_led)    mmio_rdata = 32'(led);
    else if (hit_switch) mmio_rdata = {24'b0, sw_sync};
  end

  // RAM contents survive reset; rst only blocks a write that overlaps it.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && data_sram_en && is_wr && !is_mmio)
      mem[word_idx] <= merge_bytes(mem[word_idx], data_sram_wdata, data_sram_wen);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_rdata <= '0;
      led             <= '0;
      timer           <= '0;
      err_cnt         <= '0;
      sw_meta         <= '0;
      sw_sync         <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;

      // A timer write replaces the increment; unwritten bytes keep the old count.
      if (data_sram_en && is_wr && hit_timer)
        timer <= merge_bytes(timer, data_sram_wdata, data_sram_wen);
      else
        timer <= timer + 32'd1;

      if (data_sram_en && is_wr && hit_led)
        led <= NUM_LED'(merge_bytes(32'(led), data_sram_wdata, data_sram_wen));

      if (data_sram_en && hit_none && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;

      if (data_sram_en && !is_wr)
        data_sram_rdata <= is_mmio ? mmio_rdata : mem[word_idx];
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: vector table plus hand sequences for timer,
// switch, error counter and asynchronous reset.
module tb_data_sram_resp;

  logic        clk;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  data_sram_resp #(.ADDR_W(14), .MMIO_HI(16'hBFAF), .NUM_LED(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .switch          (switch),
    .err_cnt         (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive one cycle, compare rdata after the edge, return at next negedge.
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp, input string nm);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) check({nm, "_sb_empty"}, 32'd1, 32'd0);
    else check(nm, data_sram_rdata, sb_q.pop_front());
    @(negedge clk);
  endtask

  localparam logic [31:0] A_TIMER = 32'hBFAF_E000;
  localparam logic [31:0] A_LED   = 32'hBFAF_F000;
  localparam logic [31:0] A_SW    = 32'hBFAF_F004;
  localparam logic [31:0] A_BAD   = 32'hBFAF_0100;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 16'h0000};
    vecs[1]  = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_AB00, 32'h0000_0000, 16'h0000};
    vecs[2]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h1234_AB78, 16'h0000};
    vecs[3]  = '{1'b1, 4'h0, 32'h0001_0010, 32'h0,         32'h1234_AB78, 16'h0000};
    vecs[4]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hAAAA_0000, 32'h1234_AB78, 16'h0000};
    vecs[5]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h1111_2222, 32'h1234_AB78, 16'h0000};
    vecs[6]  = '{1'b1, 4'hF, 32'h0000_0008, 32'h3333_4444, 32'h1234_AB78, 16'h0000};
    vecs[7]  = '{1'b1, 4'h9, 32'h0000_000A, 32'h9988_8877, 32'h1234_AB78, 16'h0000};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         32'hAAAA_0000, 16'h0000};
    vecs[9]  = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,         32'h1111_2222, 16'h0000};
    vecs[10] = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,         32'h9933_4477, 16'h0000};
    vecs[11] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h9933_4477, 16'h0000};
    vecs[12] = '{1'b0, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF, 32'h9933_4477, 16'h0000};
    vecs[13] = '{1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF, 32'h9933_4477, 16'h0000};
    vecs[14] = '{1'b1, 4'hF, A_LED,         32'hFFFF_5A5A, 32'h9933_4477, 16'h5A5A};
    vecs[15] = '{1'b1, 4'h0, A_LED,         32'h0,         32'h0000_5A5A, 16'h5A5A};
    vecs[16] = '{1'b1, 4'h2, A_LED,         32'h0000_C300, 32'h0000_5A5A, 16'hC35A};
    vecs[17] = '{1'b1, 4'h0, A_LED,         32'h0,         32'h0000_C35A, 16'hC35A};
    vecs[18] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 16'hC35A};

    rst = 1'b0; data_sram_en = 1'b0; data_sram_wen = '0;
    data_sram_addr = '0; data_sram_wdata = '0; switch = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_err", {24'h0, err_cnt}, 32'h0);
    rst = 1'b0;

    // Timer: 0 then 1 right after release, then cycles-since-release.
    step(1'b1, 4'h0, A_TIMER, 32'h0, 32'd0, "timer_first");
    step(1'b1, 4'h0, A_TIMER, 32'h0, 32'd1, "timer_second");
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 32'd1, "idle_hold");
    step(1'b1, 4'h0, A_TIMER, 32'h0, 32'd10, "timer_10");
    step(1'b1, 4'hF, A_TIMER, 32'hFFFF_FFFE, 32'd10, "timer_wr_hold");
    step(1'b1, 4'h2, A_TIMER, 32'h0000_3300, 32'd10, "timer_pwr_hold");
    step(1'b1, 4'h0, A_TIMER, 32'h0, 32'hFFFF_33FE, "timer_partial");
    step(1'b1, 4'hF, A_TIMER, 32'hFFFF_FFFE, 32'hFFFF_33FE, "timer_wr2_hold");
    step(1'b1, 4'h0, A_TIMER, 32'h0, 32'hFFFF_FFFE, "timer_loaded");
    step(1'b0, 4'h0, 32'h0, 32'h0, 32'hFFFF_FFFE, "timer_idle");
    step(1'b1, 4'h0, A_TIMER, 32'h0, 32'h0000_0000, "timer_wrap");

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
           $sformatf("vec%0d_rdata", i));
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
    end
    check("table_err", {24'h0, err_cnt}, 32'h0);

    // Switch through the two-flop synchroniser; write to it is not an error.
    switch = 8'hC3;
    step(1'b0, 4'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, "sw_wait0");
    step(1'b0, 4'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, "sw_wait1");
    step(1'b1, 4'h0, A_SW, 32'h0, 32'h0000_00C3, "sw_read");
    step(1'b1, 4'hF, A_SW, 32'h0000_0055, 32'h0000_00C3, "sw_write_hold");
    check("sw_write_err", {24'h0, err_cnt}, 32'h0);
    step(1'b1, 4'h0, A_SW, 32'h0, 32'h0000_00C3, "sw_read2");

    // Unmapped MMIO: alternate read/write, counter saturates at FF.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, (i % 2 == 1) ? 4'hF : 4'h0, A_BAD, 32'hFFFF_FFFF, 32'h0, "bad_rdata");
      if (i == 0)   check("err_first", {24'h0, err_cnt}, 32'h01);
      if (i == 253) check("err_254", {24'h0, err_cnt}, 32'hFE);
      if (i == 254) check("err_sat", {24'h0, err_cnt}, 32'hFF);
      if (i == 299) check("err_stay", {24'h0, err_cnt}, 32'hFF);
    end
    step(1'b1, 4'h0, A_LED, 32'h0, 32'h0000_C35A, "led_before_rst");

    // Async reset between edges while an LED write is pending.
    data_sram_en = 1'b1; data_sram_wen = 4'hF;
    data_sram_addr = A_LED; data_sram_wdata = 32'h0000_1234;
    #2 rst = 1'b1;
    #1;
    check("arst_led", {16'h0, led}, 32'h0);
    check("arst_rdata", data_sram_rdata, 32'h0);
    check("arst_err", {24'h0, err_cnt}, 32'h0);
    @(posedge clk);
    #1;
    check("arst_led_edge", {16'h0, led}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    data_sram_en = 1'b0;
    step(1'b1, 4'h0, A_TIMER, 32'h0, 32'd0, "post_rst_timer0");
    step(1'b1, 4'h0, A_TIMER, 32'h0, 32'd1, "post_rst_timer1");
    step(1'b1, 4'h0, A_LED, 32'h0, 32'h0, "post_rst_led");
    step(1'b1, 4'h0, 32'h0000_0010, 32'h0, 32'h1234_AB78, "post_rst_ram10");
    step(1'b1, 4'h0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, "post_rst_ram20");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder for the core's data SRAM port: the memory side that answers the `data_sram_*` requests the CPU core issues from EX and whose read data the core consumes in MEM. It holds a byte-writable on-chip RAM and a small MMIO window with a free-running timer, an LED register, a synchronised switch input and an unmapped-access error counter. It provides the fixed one-cycle read latency the core's pipeline depends on.

## Interface
- `ADDR_W`, 14: RAM word-address bits, giving 2^ADDR_W words.
- `MMIO_HI`, 16'hBFAF: value of `addr[31:16]` that selects the MMIO window.
- `NUM_LED`, 16: LED register width; 1..32.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_sram_en`  in  1  access request this cycle.
- `data_sram_wen`  in  4  byte write enables; bit i covers `wdata[8i+7:8i]`; 4'b0000 = read.
- `data_sram_addr`  in  32  byte address; `[1:0]` ignored.
- `data_sram_wdata`  in  32  write data.
- `data_sram_rdata`  out  32  registered read data.
- `led`  out  NUM_LED  LED register.
- `switch`  in  8  asynchronous board switches.
- `err_cnt`  out  8  count of unmapped MMIO accesses, saturating.

## Operation
- One access per cycle, valid when `en`=1. `wen`≠0 is a write and `wen`=0 is a read. With `en`=0, no state changes except the timer and the switch synchroniser.
- Decode: `addr[31:16]==MMIO_HI` selects MMIO; any other address selects RAM.
- RAM access:
  - Word index is `addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses alias.
  - RAM contents are not reset.
  - A write updates only the enabled bytes.
- MMIO offsets, decoded from `addr[15:0]` with `[1:0]` ignored:
  - 16'hE000 TIMER, read/write:
    - 32-bit counter, +1 every cycle, wraps 32'hFFFF_FFFF→0.
    - A write loads the enabled bytes. Disabled bytes keep the current value, not the incremented one.
    - In the write cycle the load replaces the increment.
  - 16'hF000 LED, read/write:
    - Byte-writable. Only bits `[NUM_LED-1:0]` are stored.
    - Reads return the upper bits as 0.
  - 16'hF004 SWITCH, read-only:
    - Returns `{24'b0, sw_sync}`, where `sw_sync` is `switch` after a two-flop synchroniser.
    - Writes are ignored and are not counted as errors.
  - Any other offset:
    - Reads return 0. Writes are ignored.
    - `err_cnt` increments by 1 for each such access, read or write, and saturates at 8'hFF.
- Read data:
  - `rdata` is loaded at the edge where a read is sampled.
  - Write cycles and idle cycles hold `rdata` at its previous value.
- TIMER read returns the counter value held before the sampling edge, i.e. the value visible during the request cycle.

## Timing
- Read latency is 1 cycle: a read sampled at edge N presents its data on `rdata` after edge N. The core captures it in MEM during cycle N+1.
- Writes take effect at the sampling edge.
- A read of the same address in the following cycle returns the written data, bytes merged.
- Back-to-back accesses are supported every cycle with no stall.
- Reset (async assertion, at any point including mid-access):
  - `rdata`=0, `led`=0, TIMER=0, `err_cnt`=0, synchroniser flops=0.
  - A request present during reset is dropped.
  - After deassertion, the first edge with `en`=1 is serviced normally.
- TIMER reads 0 in the first cycle after reset release and 1 one cycle later.
- `led` and `err_cnt` are register outputs, updated at the write/access edge.

## Test plan
- RAM write then read:
  - Write 32'h1234_5678 to 0x0000_0010 with wen=4'hF, then wen=4'b0010 with wdata=32'h0000_AB00.
  - Read 0x10 → rdata=32'h1234_AB78 one cycle after the read edge.
  - Read 0x0001_0010 (aliases with ADDR_W=14) → same value.
- Back-to-back and hold:
  - Reads of 0x0, 0x4, 0x8 on consecutive cycles → three rdata values on consecutive cycles.
  - `en`=0 afterwards → rdata holds the 0x8 value.
  - An intervening write does not change rdata.
- Timer:
  - After reset, idle 10 cycles, then read 0xBFAF_E000 → value = cycles since release.
  - Write 32'hFFFF_FFFE with wen=4'hF, then read on cycles +1 and +3 → 32'hFFFF_FFFE and 32'h0000_0000 (wrap).
- LED and switch:
  - Write 32'hFFFF_5A5A to 0xBFAF_F000 → led=16'h5A5A; read back → 32'h0000_5A5A.
  - Drive switch=8'hC3 → read of 0xBFAF_F004 issued ≥2 cycles later returns 32'h0000_00C3.
  - Write to 0xBFAF_F004 → err_cnt unchanged.
- Error counter: 300 accesses to 0xBFAF_0100 → reads return 0, err_cnt=8'hFF and stays there.
- Async reset mid-operation:
  - Assert `rst` between edges while a write to LED is pending → led=0 and rdata=0 immediately, and the write is lost.
  - After release, the RAM still holds the data written before reset.
